// File: rtl/qupls_alu_steer_pkg.sv
// qupls_alu_steer_pkg: default sizing and shared types for ALU steering
package qupls_alu_steer_pkg;
  localparam int NALU_DEF = 2;
  localparam int NSLOT_DEF = 4;
  localparam int LATW_DEF = 6;
  typedef logic [$clog2(NALU_DEF)-1:0] alu_sel_t;
  typedef logic [LATW_DEF-1:0] alu_lat_t;
endpackage

// File: rtl/qupls_alu_steer_if.sv
// qupls_alu_steer_if: decode group in, steered group out, ALU occupancy
interface qupls_alu_steer_if
  import qupls_alu_steer_pkg::*;
#(
  parameter int NALU = NALU_DEF,
  parameter int NSLOT = NSLOT_DEF,
  parameter int LATW = LATW_DEF
);
  localparam int SELW = $clog2(NALU);
  logic [NSLOT-1:0] in_valid;
  logic [NSLOT-1:0] in_alu;
  logic [NSLOT-1:0] in_alu0;
  logic [NSLOT*LATW-1:0] in_lat;
  logic [NSLOT-1:0] in_take;
  logic [NSLOT-1:0] out_valid;
  logic [NSLOT*SELW-1:0] out_alu;
  logic out_ready;
  logic [NALU-1:0] alu_busy;
  modport master (
    output in_valid, in_alu, in_alu0, in_lat, out_ready,
    input in_take, out_valid, out_alu, alu_busy
  );
  modport slave (
    input in_valid, in_alu, in_alu0, in_lat, out_ready,
    output in_take, out_valid, out_alu, alu_busy
  );
endinterface

// File: rtl/qupls_alu_steer_busy_ctr.sv
// qupls_alu_busy_ctr: issue-port occupancy counter for one ALU
module qupls_alu_busy_ctr #(
  parameter int LATW = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_i,
  input  logic [LATW-1:0] lat_i,
  output logic busy_o
);
  logic [LATW-1:0] ctr_q, ctr_d;
  // a multi-cycle issue reloads the count; otherwise drain to zero
  always_comb ctr_d = (ld_i && lat_i > LATW'(1)) ? lat_i - LATW'(1) : (ctr_q != '0) ? ctr_q - LATW'(1) : ctr_q;
  // occupancy tracks the ALU itself, so it never waits on the handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) ctr_q <= '0;
    else ctr_q <= ctr_d;
  assign busy_o = ctr_q != '0;
endmodule

// File: rtl/qupls_alu_steer.sv
// qupls_alu_steer: assigns the longest steerable prefix of a decode group to ALUs
module qupls_alu_steer
  import qupls_alu_steer_pkg::*;
#(
  parameter int NALU = NALU_DEF,
  parameter int NSLOT = NSLOT_DEF,
  parameter int LATW = LATW_DEF
) (
  input logic clk,
  input logic rst,
  qupls_alu_steer_if.slave s
);
  localparam int SELW = $clog2(NALU);
  logic free, stop, ok;
  logic [NSLOT-1:0] take, valid_q;
  logic [NSLOT*SELW-1:0] alu_d, alu_q;
  logic [SELW-1:0] rr_q, rr_d, pick, cand;
  logic [NALU-1:0] claim, ld, busy;
  logic [NALU*LATW-1:0] ld_lat;
  assign free = !(|valid_q) | s.out_ready;
  // walk slots in order; the first one that cannot get an ALU ends the prefix
  always_comb begin
    claim = busy;
    stop = !free;
    take = '0;
    alu_d = '0;
    ld = '0;
    ld_lat = '0;
    rr_d = rr_q;
    ok = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 0; k < NSLOT; k++) begin
      ok = !s.in_alu[k];
      pick = '0;
      if (s.in_alu[k] && s.in_alu0[k]) ok = !claim[0];
      else if (s.in_alu[k])
        for (int j = NALU - 1; j >= 0; j--) begin
          cand = (int'(rr_q) + j >= NALU) ? SELW'(int'(rr_q) + j - NALU) : SELW'(int'(rr_q) + j);
          if (!claim[cand]) begin
            ok = 1'b1;
            pick = cand;
          end
        end
      if (!stop && s.in_valid[k] && ok) begin
        take[k] = 1'b1;
        if (s.in_alu[k]) begin
          alu_d[k*SELW +: SELW] = pick;
          claim[pick] = 1'b1;
          ld[pick] = 1'b1;
          ld_lat[pick*LATW +: LATW] = s.in_lat[k*LATW +: LATW];
          if (!s.in_alu0[k]) rr_d = (int'(pick) == NALU - 1) ? '0 : pick + SELW'(1);
        end
      end else stop = 1'b1;
    end
  end
  // output stage loads whenever it is empty or being drained
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      alu_q <= '0;
      rr_q <= '0;
    end else if (free) begin
      valid_q <= take;
      alu_q <= alu_d;
      rr_q <= rr_d;
    end
  for (genvar i = 0; i < NALU; i++) begin : g_ctr
    qupls_alu_busy_ctr #(.LATW(LATW)) u_ctr (
      .clk(clk),
      .rst(rst),
      .ld_i(ld[i]),
      .lat_i(ld_lat[i*LATW +: LATW]),
      .busy_o(busy[i])
    );
  end
  assign s.in_take = take;
  assign s.out_valid = valid_q;
  assign s.out_alu = alu_q;
  assign s.alu_busy = busy;
endmodule

// File: tb/tb_qupls_alu_steer.sv
// tb_qupls_alu_steer: directed and random checks against a behavioural steering model
module tb_qupls_alu_steer;
  localparam int NALU = 2;
  localparam int NSLOT = 4;
  localparam int LATW = 6;
  localparam int SELW = $clog2(NALU);
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_busy[NALU];
  int m_rr;
  logic [NSLOT-1:0] m_ov;
  int m_alu[NSLOT];
  logic [NSLOT-1:0] e_take;
  int e_alu[NSLOT];
  int e_load[NALU];
  int e_rr;
  bit e_free;
  logic [NSLOT-1:0] got_take;
  int busy_hits;
  qupls_alu_steer_if #(.NALU(NALU), .NSLOT(NSLOT), .LATW(LATW)) bi ();
  qupls_alu_steer #(.NALU(NALU), .NSLOT(NSLOT), .LATW(LATW)) dut (.clk(clk), .rst(rst), .s(bi));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [NSLOT*LATW-1:0] lt(input int l0, input int l1, input int l2, input int l3);
    return {LATW'(l3), LATW'(l2), LATW'(l1), LATW'(l0)};
  endfunction
  function automatic int slot_alu(input int k);
    return int'(bi.out_alu[k*SELW +: SELW]);
  endfunction
  function automatic void model_reset();
    m_rr = 0;
    m_ov = '0;
    for (int i = 0; i < NALU; i++) m_busy[i] = 0;
    for (int k = 0; k < NSLOT; k++) m_alu[k] = 0;
  endfunction
  // pick = -1 means no ALU needed, -2 means the slot cannot be taken
  function automatic void predict(input logic [NSLOT-1:0] v, input logic [NSLOT-1:0] a,
                                  input logic [NSLOT-1:0] a0, input logic [NSLOT*LATW-1:0] l, input logic r);
    bit claimed[NALU];
    bit stop;
    int pick;
    e_free = (m_ov == '0) || r;
    e_take = '0;
    e_rr = m_rr;
    stop = !e_free;
    for (int i = 0; i < NALU; i++) begin
      e_load[i] = -1;
      claimed[i] = m_busy[i] > 0;
    end
    for (int k = 0; k < NSLOT; k++) begin
      e_alu[k] = 0;
      pick = -2;
      if (!stop && v[k]) begin
        if (!a[k]) pick = -1;
        else if (a0[k]) pick = claimed[0] ? -2 : 0;
        else
          for (int j = 0; j < NALU; j++)
            if (pick == -2 && !claimed[(m_rr + j) % NALU]) pick = (m_rr + j) % NALU;
      end
      if (pick == -2) stop = 1;
      else begin
        e_take[k] = 1'b1;
        if (pick >= 0) begin
          claimed[pick] = 1;
          e_alu[k] = pick;
          e_load[pick] = int'(l[k*LATW +: LATW]);
          if (!a0[k]) e_rr = (pick + 1) % NALU;
        end
      end
    end
  endfunction
  function automatic void commit();
    for (int i = 0; i < NALU; i++)
      if (e_load[i] > 1) m_busy[i] = e_load[i] - 1;
      else if (m_busy[i] > 0) m_busy[i] = m_busy[i] - 1;
    if (e_free) begin
      m_ov = e_take;
      m_rr = e_rr;
      for (int k = 0; k < NSLOT; k++) m_alu[k] = e_alu[k];
    end
  endfunction
  task automatic check_outputs();
    chk("out_valid", int'(bi.out_valid), int'(m_ov));
    for (int k = 0; k < NSLOT; k++)
      if (m_ov[k]) chk("out_alu", slot_alu(k), m_alu[k]);
    for (int i = 0; i < NALU; i++) chk("alu_busy", int'(bi.alu_busy[i]), int'(m_busy[i] > 0));
  endtask
  // called just after a falling edge; returns at the next falling edge
  task automatic step(input logic [NSLOT-1:0] v, input logic [NSLOT-1:0] a, input logic [NSLOT-1:0] a0,
                      input logic [NSLOT*LATW-1:0] l, input logic r);
    bi.in_valid = v;
    bi.in_alu = a;
    bi.in_alu0 = a0;
    bi.in_lat = l;
    bi.out_ready = r;
    predict(v, a, a0, l, r);
    #1;
    got_take = bi.in_take;
    chk("in_take", int'(got_take), int'(e_take));
    @(posedge clk);
    commit();
    @(negedge clk);
    check_outputs();
  endtask
  initial begin
    bi.in_valid = '0;
    bi.in_alu = '0;
    bi.in_alu0 = '0;
    bi.in_lat = '0;
    bi.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset out_valid", int'(bi.out_valid), 0);
    chk("reset alu_busy", int'(bi.alu_busy), 0);
    rst = 1'b0;
    step(4'b1111, 4'b1111, 4'b0000, lt(1, 1, 1, 1), 1'b1);
    chk("prefix take", int'(got_take), 4'b0011);
    chk("prefix alu0", slot_alu(0), 0);
    chk("prefix alu1", slot_alu(1), 1);
    step(4'b0011, 4'b0011, 4'b0000, lt(1, 1, 0, 0), 1'b1);
    chk("prefix rest take", int'(got_take), 4'b0011);
    chk("prefix rr wrap", slot_alu(0), 0);
    step(4'b0001, 4'b0001, 4'b0001, lt(20, 0, 0, 0), 1'b1);
    chk("lat20 take", int'(got_take), 4'b0001);
    busy_hits = int'(bi.alu_busy[0]);
    for (int n = 0; n < 18; n++) begin
      step(4'b0001, 4'b0001, 4'b0000, lt(1, 0, 0, 0), 1'b1);
      chk("any while busy", slot_alu(0), 1);
      busy_hits += int'(bi.alu_busy[0]);
    end
    step(4'b0001, 4'b0001, 4'b0001, lt(1, 0, 0, 0), 1'b1);
    chk("alu0 blocked", int'(got_take), 0);
    busy_hits += int'(bi.alu_busy[0]);
    chk("busy cycles", busy_hits, 19);
    step(4'b0001, 4'b0001, 4'b0001, lt(1, 0, 0, 0), 1'b1);
    chk("alu0 after drop", int'(got_take), 4'b0001);
    step(4'b0001, 4'b0001, 4'b0000, lt(1, 0, 0, 0), 1'b1);
    step(4'b1111, 4'b1110, 4'b1010, lt(1, 1, 1, 1), 1'b1);
    chk("mixed take", int'(got_take), 4'b0111);
    chk("mixed alu s0", slot_alu(0), 0);
    chk("mixed alu s1", slot_alu(1), 0);
    chk("mixed alu s2", slot_alu(2), 1);
    step(4'b0001, 4'b0001, 4'b0001, lt(5, 0, 0, 0), 1'b1);
    for (int n = 0; n < 3; n++) begin
      step(4'b1111, 4'b1111, 4'b0000, lt(1, 1, 1, 1), 1'b0);
      chk("stall take", int'(got_take), 0);
      chk("stall hold", int'(bi.out_valid), 4'b0001);
    end
    step(4'b0000, 4'b0000, 4'b0000, lt(0, 0, 0, 0), 1'b1);
    step(4'b0001, 4'b0001, 4'b0000, lt(1, 0, 0, 0), 1'b1);
    step(4'b0011, 4'b0001, 4'b0001, lt(11, 1, 0, 0), 1'b1);
    chk("pre-reset valid", int'(bi.out_valid), 4'b0011);
    bi.in_valid = '0;
    rst = 1'b1;
    #1;
    chk("async rst busy", int'(bi.alu_busy), 0);
    chk("async rst valid", int'(bi.out_valid), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0001, 4'b0001, 4'b0001, lt(1, 0, 0, 0), 1'b1);
    chk("post-reset alu0", int'(got_take), 4'b0001);
    step(4'b0001, 4'b0001, 4'b0000, lt(1, 0, 0, 0), 1'b1);
    chk("post-reset rr", slot_alu(0), 0);
    for (int n = 0; n < 2; n++) begin
      step(4'b0001, 4'b0001, 4'b0001, lt(0, 0, 0, 0), 1'b1);
      chk("lat0 take", int'(got_take), 4'b0001);
      chk("lat0 busy", int'(bi.alu_busy[0]), 0);
    end
    for (int n = 0; n < 3000; n++) begin
      logic [NSLOT*LATW-1:0] l;
      for (int k = 0; k < NSLOT; k++)
        l[k*LATW +: LATW] = LATW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2));
      step(NSLOT'($urandom), NSLOT'($urandom), NSLOT'($urandom & $urandom), l, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qupls_alu_steer.md
# qupls_alu_steer

Parametrised ALU steering stage between decode/rename and the ALU reservation stations. It generalises the single "ALU #0 only" classification to NALU ALUs. It assigns each decoded slot of an NSLOT-wide group to a specific ALU, honouring ALU0-only instructions (CPUID, multiply, divide, CSR, BSR/JSR, PRED, CAP, …), and tracks multi-cycle occupancy per ALU. It accepts the longest assignable prefix of the group each cycle and presents assignments through one registered output stage with a valid/ready handshake.

## Interface
Parameters:
- NALU, 2: number of ALUs, legal 2..4; ALU 0 is the only ALU able to execute ALU0-only ops.
- NSLOT, 4: decode group width.
- LATW, 6: width of the per-slot occupancy field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NSLOT  slot holds a live instruction.
- in_alu  in  NSLOT  slot is an ALU instruction (needs an ALU).
- in_alu0  in  NSLOT  slot must execute on ALU 0; ignored unless in_alu is set.
- in_lat  in  NSLOT*LATW  cycles the op occupies its ALU issue port; 0 and 1 both mean fully pipelined.
- in_take  out  NSLOT  combinational; slots consumed this cycle, always a contiguous prefix from slot 0.
- out_valid  out  NSLOT  registered; slots presented downstream.
- out_alu  out  NSLOT*$clog2(NALU)  registered ALU index per slot; 0 for non-ALU slots.
- out_ready  in  1  downstream accepts the output register this cycle.
- alu_busy  out  NALU  registered; ALU occupancy counter non-zero.

## Operation
- Output stage free (load enable) = !(|out_valid) | out_ready. If not free: in_take = 0, and output registers hold.
- Slots are evaluated in order 0..NSLOT-1 against a per-cycle claim mask. The claim mask is initialised to alu_busy, and each ALU accepts at most one op per cycle.
- Slot not valid: it terminates the prefix. Later slots are not taken.
- Valid, !in_alu: always assignable. It claims no ALU and gets out_alu = 0.
- Valid, in_alu & in_alu0: assignable iff ALU 0 is unclaimed. It then claims ALU 0.
- Valid, in_alu & !in_alu0: searches ALUs rr, rr+1, … mod NALU. It takes the first unclaimed ALU and claims it.
- The first unassignable slot ends the prefix. in_take covers exactly the assigned slots.
- On load: out_valid <= in_take, and out_alu <= the assignments. Untaken slots load out_valid = 0.
- Round-robin pointer rr: on load, rr <= (index of the last any-ALU assignment in the group + 1) mod NALU. rr is unchanged if the group has no such assignment.
- Busy counters, one per ALU, LATW bits wide:
  - On an assignment with lat > 1, the counter loads lat-1.
  - Otherwise the counter decrements when non-zero and saturates at 0.
  - A load in the cycle the counter would reach 0 takes priority.
  - alu_busy[i] = (ctr[i] != 0). An ALU becomes assignable the cycle after its counter reads 0.
- Counters run independently of out_ready, because occupancy models the ALU, not the handshake.

## Timing
- Reset values: out_valid = 0, out_alu = 0, rr = 0, all counters 0, alu_busy = 0.
- rst asserted mid-operation clears everything immediately. Any in-flight group in the output register is dropped.
- Latency: in_take is combinational in the same cycle. Assignments appear on out_valid/out_alu one clock later.
- An op with lat = L blocks its ALU for exactly L-1 following cycles.
- Output register contents are stable while out_valid != 0 and out_ready = 0.

## Structure
- QuplsPkg additions: typedef alu_sel_t (logic [$clog2(NALU)-1:0]); typedef alu_lat_t (logic [LATW-1:0]).
- Sub-module qupls_alu_busy_ctr: one counter per ALU, with load/decrement/saturate logic and a busy output. It is instantiated NALU times via generate.
- Prefix/claim logic is a combinational always_comb loop over slots. It must not contain latches.

## Test plan
- Pipelined prefix: NALU=2, rr=0, out_ready=1, four valid any-ALU slots with lat=1.
  - Cycle 0: in_take = 0011.
  - Next cycle: out_alu = {-,-,1,0}, and rr = 0.
  - The remaining two slots are taken the following cycle.
- ALU0 occupancy: slot0 is alu0 with lat=20, and all other slots are invalid.
  - alu_busy[0] is high for 19 cycles.
  - A following alu0 slot is not taken until alu_busy[0] drops.
  - Any-ALU slots are still steered to ALU 1 in the meantime.
- Mixed group: slots = {non-ALU, alu0, any, alu0}, rr=1, nothing busy.
  - in_take = 0111.
  - out_alu = {0,0,1} for slots 0..2.
  - Slot 3 is blocked by the ALU 0 claim.
- Backpressure: out_valid != 0 and out_ready = 0 for 3 cycles.
  - in_take = 0 throughout, and outputs are unchanged.
  - Busy counters still decrement.
- Reset: assert rst while ctr[0] = 10 and out_valid = 0011.
  - Without waiting for a clock edge: alu_busy = 0, out_valid = 0, rr = 0.
  - After release, a new alu0 op is taken in the first cycle.
- Lat 0 vs 1: an alu0 op with lat=0 followed next cycle by another alu0 op.
  - Both are taken back-to-back.
  - alu_busy[0] never asserts.
